// File: rtl/dco_freq_detector.sv
// Counter-based DCO frequency detector: counts dco_clk cycles per reference period and
// strobes active-low up/down requests to the PLL controller. Optional lock: DCO_FREQ_DETECTOR_LOCK_DETECT_EN.
module dco_freq_detector #(
  parameter int CW       = 10,
  parameter int TOL      = 1,
  parameter int PH_HI    = 4,
  parameter int LOCK_CNT = 8
) (
  input  logic          dco_clk,
  input  logic          reset_n,
  input  logic          ref_in,
  input  logic [CW-1:0] div_ratio,
  output logic          p_up,
  output logic          p_down,
  output logic          phase_clk,
  output logic          in_band,
  output logic [CW-1:0] count_out
`ifdef DCO_FREQ_DETECTOR_LOCK_DETECT_EN
  ,
  output logic          lock
`endif
);

  localparam int            PW      = $clog2(PH_HI + 1);
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW:0]   TOL_X   = (CW+1)'(TOL);

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_EVAL, S_STROBE} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_ref_s1, r_ref_s2, r_ref_d;
  logic          w_ref_rise;
  logic [CW-1:0] r_cnt, r_cap;
  logic          r_pend;
  logic [PW-1:0] r_ph_cnt;
  logic          w_ph_done;
  logic          r_phase, r_p_up, r_p_down, r_in_band;
  logic [CW-1:0] r_count_out;
  logic [CW:0]   w_cap_x, w_div_x, w_lo, w_hi;
  logic          w_below, w_above;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + CW'(1);
  endfunction

  // ref_in synchronizer and rising-edge detect
  always_ff @(posedge dco_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ref_s1 <= 1'b0;
      r_ref_s2 <= 1'b0;
      r_ref_d  <= 1'b0;
    end else begin
      r_ref_s1 <= ref_in;
      r_ref_s2 <= r_ref_s1;
      r_ref_d  <= r_ref_s2;
    end
  end

  assign w_ref_rise = r_ref_s2 & ~r_ref_d;

  // Period counter never stalls; every edge refreshes the capture register
  always_ff @(posedge dco_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_cap <= '0;
    end else if (w_ref_rise) begin
      r_cap <= r_cnt;
      r_cnt <= CW'(1);
    end else begin
      r_cnt <= sat_inc(r_cnt);
    end
  end

  // Captures landing while a result is being presented wait here (1-deep)
  always_ff @(posedge dco_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend <= 1'b0;
    end else if (w_state_nxt == S_EVAL) begin
      r_pend <= 1'b0;
    end else if (w_ref_rise && (r_state == S_EVAL || r_state == S_STROBE)) begin
      r_pend <= 1'b1;
    end
  end

  assign w_ph_done = (r_ph_cnt == PW'(PH_HI));

  always_ff @(posedge dco_clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_ref_rise) w_state_nxt = S_COUNT;
      S_COUNT:  if (w_ref_rise) w_state_nxt = S_EVAL;
      S_EVAL:   w_state_nxt = S_STROBE;
      S_STROBE: if (w_ph_done) w_state_nxt = (r_pend || w_ref_rise) ? S_EVAL : S_COUNT;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Strobe shaping: high for PH_HI cycles beginning one cycle after EVAL
  always_ff @(posedge dco_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ph_cnt <= '0;
      r_phase  <= 1'b0;
    end else if (r_state == S_STROBE && !w_ph_done) begin
      r_ph_cnt <= r_ph_cnt + PW'(1);
      r_phase  <= 1'b1;
    end else begin
      r_ph_cnt <= '0;
      r_phase  <= 1'b0;
    end
  end

  // Window comparison, one bit wider so div_ratio+TOL cannot wrap
  assign w_cap_x = {1'b0, r_cap};
  assign w_div_x = {1'b0, div_ratio};
  assign w_lo    = (w_div_x >= TOL_X) ? (w_div_x - TOL_X) : '0;
  assign w_hi    = w_div_x + TOL_X;
  assign w_below = (w_cap_x < w_lo);
  assign w_above = (w_cap_x > w_hi);

  always_ff @(posedge dco_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_p_up      <= 1'b1;
      r_p_down    <= 1'b1;
      r_in_band   <= 1'b0;
      r_count_out <= '0;
    end else if (r_state == S_EVAL) begin
      r_count_out <= r_cap;
      r_p_up      <= ~w_below;
      r_p_down    <= ~w_above;
      r_in_band   <= ~w_below & ~w_above;
    end
  end

  assign p_up      = r_p_up;
  assign p_down    = r_p_down;
  assign phase_clk = r_phase;
  assign in_band   = r_in_band;
  assign count_out = r_count_out;

`ifdef DCO_FREQ_DETECTOR_LOCK_DETECT_EN
  localparam int RW = $clog2(LOCK_CNT + 1);

  logic [RW-1:0] r_run;
  logic          r_lock;

  always_ff @(posedge dco_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_run  <= '0;
      r_lock <= 1'b0;
    end else if (r_state == S_EVAL) begin
      if (!w_below && !w_above) begin
        if (r_run != RW'(LOCK_CNT)) r_run <= r_run + RW'(1);
        r_lock <= (r_run >= RW'(LOCK_CNT - 1));
      end else begin
        r_run  <= '0;
        r_lock <= 1'b0;
      end
    end
  end

  assign lock = r_lock;
`endif

endmodule

// File: tb/tb_dco_freq_detector.sv
// Self-checking bench for dco_freq_detector: vector table, hand sequences for reset,
// latency and overlapping edges, and randomized windows against a window-level model.
module tb_dco_freq_detector;

  localparam int CW       = 10;
  localparam int TOL      = 1;
  localparam int PH_HI    = 4;
  localparam int LOCK_CNT = 8;
  localparam int CMAX     = (1 << CW) - 1;

  logic          dco_clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          ref_in  = 1'b0;
  logic [CW-1:0] div_ratio = CW'(100);
  logic          p_up, p_down, phase_clk, in_band;
  logic [CW-1:0] count_out;
`ifdef DCO_FREQ_DETECTOR_LOCK_DETECT_EN
  logic          lock;
`endif

  dco_freq_detector #(.CW(CW), .TOL(TOL), .PH_HI(PH_HI), .LOCK_CNT(LOCK_CNT)) u_dut (
    .dco_clk   (dco_clk),
    .reset_n   (reset_n),
    .ref_in    (ref_in),
    .div_ratio (div_ratio),
    .p_up      (p_up),
    .p_down    (p_down),
    .phase_clk (phase_clk),
    .in_band   (in_band),
    .count_out (count_out)
`ifdef DCO_FREQ_DETECTOR_LOCK_DETECT_EN
    ,
    .lock      (lock)
`endif
  );

  always #5 dco_clk = ~dco_clk;

  typedef struct { int cnt; int div; } exp_t;
  typedef struct { int period; int div; int cnt; int up; int dn; int inb; } vec_t;

  int   n_chk = 0, n_pass = 0;
  int   cyc = 0;
  int   last_rise = 0;
  bit   have_prev = 0;
  bit   model_on = 1;
  int   run_m = 0;
  int   n_strobes = 0;
  int   width = 0;
  bit   ph_prev = 0;
  int   f_count = 0, f_up = 0, f_dn = 0, f_inb = 0, f_lock = 0;
  exp_t exp_q[$];

  always @(posedge dco_clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Strobe monitor: every falling phase_clk edge presents one evaluated window
  always @(negedge dco_clk) begin
    if (!reset_n) begin
      ph_prev = 0;
      width   = 0;
    end else begin
      if (phase_clk) width++;
      if (ph_prev && !phase_clk) begin
        n_strobes++;
        f_count = int'(count_out);
        f_up    = int'(p_up);
        f_dn    = int'(p_down);
        f_inb   = int'(in_band);
`ifdef DCO_FREQ_DETECTOR_LOCK_DETECT_EN
        f_lock  = int'(lock);
`endif
        check("strobe_width", width, PH_HI);
        check("up_down_exclusive", int'(!p_up && !p_down), 0);
        if (model_on) begin
          check("strobe_has_window", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            exp_t e;
            int lo, hi, inb;
            e  = exp_q.pop_front();
            lo = (e.div - TOL < 0) ? 0 : e.div - TOL;
            hi = e.div + TOL;
            inb = (e.cnt >= lo && e.cnt <= hi) ? 1 : 0;
            check("model_count", int'(count_out), e.cnt);
            check("model_p_up", int'(p_up), (e.cnt < lo) ? 0 : 1);
            check("model_p_down", int'(p_down), (e.cnt > hi) ? 0 : 1);
            check("model_in_band", int'(in_band), inb);
`ifdef DCO_FREQ_DETECTOR_LOCK_DETECT_EN
            run_m = inb ? ((run_m < LOCK_CNT) ? run_m + 1 : LOCK_CNT) : 0;
            check("model_lock", int'(lock), int'(run_m == LOCK_CNT));
`endif
          end
        end
        width = 0;
      end
      ph_prev = phase_clk;
    end
  end

  // One reference period of p dco cycles measured from the previous rising edge
  task automatic window(input int p, input int d);
    int c;
    while (cyc < last_rise + p / 2) begin @(posedge dco_clk); #1; end
    ref_in = 1'b0;
    while (cyc < last_rise + p) begin @(posedge dco_clk); #1; end
    div_ratio = CW'(d);
    ref_in    = 1'b1;
    c = cyc - last_rise;
    if (have_prev) exp_q.push_back('{(c > CMAX) ? CMAX : c, d});
    have_prev = 1;
    last_rise = cyc;
  endtask

  task automatic wait_strobes(input int start, input int n);
    int t = 0;
    while (n_strobes < start + n && t < 3000) begin @(posedge dco_clk); #1; t++; end
    check("strobe_arrived", int'(n_strobes >= start + n), 1);
  endtask

  vec_t tbl[12];

  initial begin
    int s;
    tbl[0]  = '{100,  100,  100,  1, 1, 1};
    tbl[1]  = '{90,   100,  90,   0, 1, 0};
    tbl[2]  = '{110,  100,  110,  1, 0, 0};
    tbl[3]  = '{99,   100,  99,   1, 1, 1};
    tbl[4]  = '{101,  100,  101,  1, 1, 1};
    tbl[5]  = '{98,   100,  98,   0, 1, 0};
    tbl[6]  = '{102,  100,  102,  1, 0, 0};
    tbl[7]  = '{20,   0,    20,   1, 0, 0};
    tbl[8]  = '{1500, 100,  1023, 1, 0, 0};
    tbl[9]  = '{14,   1023, 14,   0, 1, 0};
    tbl[10] = '{1500, 1023, 1023, 1, 1, 1};
    tbl[11] = '{1500, 1022, 1023, 1, 1, 1};

    repeat (3) @(posedge dco_clk);
    #1;
    check("rst_p_up", int'(p_up), 1);
    check("rst_p_down", int'(p_down), 1);
    check("rst_phase_clk", int'(phase_clk), 0);
    check("rst_in_band", int'(in_band), 0);
    check("rst_count_out", int'(count_out), 0);
`ifdef DCO_FREQ_DETECTOR_LOCK_DETECT_EN
    check("rst_lock", int'(lock), 0);
`endif
    reset_n   = 1'b1;
    last_rise = cyc;

    // First window after reset is partial and must not strobe
    window(50, 100);
    repeat (15) @(posedge dco_clk);
    #1;
    check("first_window_discarded", n_strobes, 0);

    for (int i = 0; i < 12; i++) begin
      s = n_strobes;
      window(tbl[i].period, tbl[i].div);
      wait_strobes(s, 1);
      check($sformatf("vec%0d_count", i), f_count, tbl[i].cnt);
      check($sformatf("vec%0d_p_up", i), f_up, tbl[i].up);
      check($sformatf("vec%0d_p_down", i), f_dn, tbl[i].dn);
      check($sformatf("vec%0d_in_band", i), f_inb, tbl[i].inb);
    end

    // Asynchronous reset in the middle of a strobe
    window(110, 100);
    for (int t = 0; t < 50 && !phase_clk; t++) begin @(posedge dco_clk); #1; end
    check("strobe_high_before_reset", int'(phase_clk), 1);
    check("p_down_before_reset", int'(p_down), 0);
    ref_in  = 1'b0;
    reset_n = 1'b0;
    #1;
    check("midreset_phase_clk", int'(phase_clk), 0);
    check("midreset_p_up", int'(p_up), 1);
    check("midreset_p_down", int'(p_down), 1);
    check("midreset_count_out", int'(count_out), 0);
    exp_q.delete();
    have_prev = 0;
    run_m     = 0;
    repeat (3) @(posedge dco_clk);
    #1;
    reset_n   = 1'b1;
    last_rise = cyc;
    s = n_strobes;
    window(60, 100);
    repeat (15) @(posedge dco_clk);
    #1;
    check("post_reset_discard", n_strobes - s, 0);
    window(100, 100);
    wait_strobes(s, 1);

    // Output and strobe latency relative to the ref_in edge
    s = n_strobes;
    window(120, 100);
    repeat (3) begin @(posedge dco_clk); #1; end
    check("lat_count_before_eval", int'(count_out), 100);
    @(posedge dco_clk); #1;
    check("lat_count_after_eval", int'(count_out), 120);
    check("lat_phase_still_low", int'(phase_clk), 0);
    @(posedge dco_clk); #1;
    check("lat_phase_rises", int'(phase_clk), 1);
    wait_strobes(s, 1);

    // Two edges land during one strobe: the later one overwrites the pending count
    model_on = 0;
    s = n_strobes;
    window(100, 100);
    window(2, 100);
    window(3, 100);
    wait_strobes(s, 2);
    check("pending_latest_count", f_count, 3);
    check("pending_p_up", f_up, 0);
    check("pending_p_down", f_dn, 1);
    check("pending_in_band", f_inb, 0);
    repeat (20) @(posedge dco_clk);
    #1;
    check("pending_no_extra_strobe", n_strobes - s, 2);
    exp_q.delete();
    run_m    = 0;
    model_on = 1;
    s = n_strobes;
    window(100, 100);
    wait_strobes(s, 1);

    // Randomized windows, mostly near the target
    for (int i = 0; i < 40; i++) begin
      int d, p;
      d = $urandom_range(90, 110);
      if ($urandom_range(0, 3) == 0) p = $urandom_range(8, 300);
      else p = d + $urandom_range(0, 4) - 2;
      window(p, d);
    end
    s = n_strobes;
    wait_strobes(s, 1);
    repeat (20) @(posedge dco_clk);
    #1;
    check("random_queue_drained", exp_q.size(), 0);

`ifdef DCO_FREQ_DETECTOR_LOCK_DETECT_EN
    s = n_strobes;
    window(150, 100);
    wait_strobes(s, 1);
    check("lock_cleared", f_lock, 0);
    for (int i = 1; i <= LOCK_CNT; i++) begin
      s = n_strobes;
      window(100, 100);
      wait_strobes(s, 1);
      check($sformatf("lock_after_%0d", i), f_lock, int'(i == LOCK_CNT));
    end
    s = n_strobes;
    window(105, 100);
    wait_strobes(s, 1);
    check("lock_drop", f_lock, 0);
    check("lock_drop_p_down", f_dn, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
